collision_seq: RTL and testbench
================================

# collision_seq

Frame-rate collision sequencer for the Ping-Pong game. On each frame-tick start pulse it snapshots the ball and paddle positions, then time-multiplexes one shared external 8-bit unsigned less-than comparator across eight checks, one check per cycle. From the eight results it produces paddle hit/miss and wall-bounce flags for the game FSM. Using one comparator replaces eight parallel comparators with a single instance plus this sequencer.

## Interface
- X_LEFT, 8: ball_x below this value means the ball is at the left paddle plane.
- X_RIGHT, 247: ball_x above this value means the ball is at the right paddle plane.
- PAD_H, 32: paddle height in pixels; 8-bit.
- Y_TOP, 4: ball_y below this value means a top-wall bounce.
- Y_BOT, 251: ball_y above this value means a bottom-wall bounce.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run one collision pass.
- ball_x, ball_y  in  8 each  ball position.
- pad_l_y, pad_r_y  in  8 each  paddle top y coordinate.
- cmp_a, cmp_b  out  8 each  operands driven to the shared comparator.
- cmp_lt  in  1  comparator result, combinational (cmp_a < cmp_b, unsigned).
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse: result flags updated.
- hit_l, miss_l, hit_r, miss_r, wall_top, wall_bot  out  1 each  results, held until the next done.

## Operation
- States: IDLE, CMP (step counter 0..7), FIN.
- IDLE
  - start=1 snapshots ball_x, ball_y, pad_l_y and pad_r_y, clears step to 0, and enters CMP.
  - start=0 stays in IDLE.
- Paddle end: pad_*_end = min(pad_*_y + PAD_H, 255). Compute the sum 9 bits wide and saturate to 255.
- CMP: each step drives (cmp_a, cmp_b) from the snapshot registers and registers cmp_lt into scratch bit s[step] at the end of the cycle. Steps:
  - step 0: (ball_x, X_LEFT)
  - step 1: (ball_y, pad_l_y)
  - step 2: (ball_y, pad_l_end)
  - step 3: (X_RIGHT, ball_x)
  - step 4: (ball_y, pad_r_y)
  - step 5: (ball_y, pad_r_end)
  - step 6: (ball_y, Y_TOP)
  - step 7: (Y_BOT, ball_y)
- Step 7 captured: go to FIN.
- FIN: on the clock edge that leaves FIN, register the results, set done=1 and return to IDLE.
  - hit_l = s0 & ~s1 & s2; miss_l = s0 & ~hit_l.
  - hit_r = s3 & ~s4 & s5; miss_r = s3 & ~hit_r.
  - wall_top = s6; wall_bot = s7.
- cmp_a and cmp_b are 0 in IDLE and FIN.
- start while busy is ignored, including in FIN; it is not queued.
- Input changes after the snapshot do not affect the pass in progress.
- hit_* and miss_* are mutually exclusive per side.
- Paddle span is inclusive of the top and exclusive of the end: ball_y = pad_y is a hit, ball_y = pad_end is a miss.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, step=0, scratch=0.
  - busy=0, done=0, all result flags=0, cmp_a=cmp_b=0.
- Reset mid-pass aborts the pass; no done is produced.
- Let E0 be the edge that samples start=1 in IDLE.
  - Step k is captured at edge E(k+1); step 7 at E8.
  - FIN occupies the cycle between E8 and E9.
  - At E9: result flags update and done rises; done falls at E10.
- busy = (state != IDLE): 1 from E0 to E9, 0 during the done cycle.
- Latency: 9 clocks from start to done. The next start is accepted at E10 at the earliest (start high during the done cycle), so one pass needs at least 10 cycles.
- cmp_a and cmp_b come from registered state only and change just after the edge. cmp_lt must settle within one cycle.

## Test plan
- Reset: assert rst_n=0 mid-pass at step 4 -> busy, done, all flags and cmp_a/cmp_b go 0 immediately; the pass does not resume after release.
- Left hit: ball (5,100), pad_l_y=90, start -> done exactly 9 cycles after the start edge; hit_l=1, all other flags 0; step 2 drives cmp_a=100, cmp_b=122.
- Left boundaries:
  - ball (5,122), pad_l_y=90 -> miss_l=1, hit_l=0.
  - ball (5,90) -> hit_l=1.
- Right miss with top wall: ball (250,2), pad_r_y=200 -> miss_r=1, wall_top=1, hit_r=0.
- Saturation: pad_r_y=240, ball (250,255) -> step 5 drives cmp_b=255; miss_r=1, wall_bot=1.
- Start and snapshot handling:
  - Re-pulse start and change ball_y while busy -> the second start is ignored and the flags reflect the snapshot taken at E0.
  - Pulse start during the done cycle -> a new pass begins and its done arrives 9 cycles later.

Source files
------------

// File: rtl/collision_seq.sv
// Collision sequencer: snapshots ball/paddle positions on start and time-shares one
// external unsigned less-than comparator over eight checks to form hit/miss/wall flags.
module collision_seq #(
  parameter logic [7:0] X_LEFT  = 8'd8,
  parameter logic [7:0] X_RIGHT = 8'd247,
  parameter logic [7:0] PAD_H   = 8'd32,
  parameter logic [7:0] Y_TOP   = 8'd4,
  parameter logic [7:0] Y_BOT   = 8'd251
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ball_x,
  input  logic [7:0] ball_y,
  input  logic [7:0] pad_l_y,
  input  logic [7:0] pad_r_y,
  output logic [7:0] cmp_a,
  output logic [7:0] cmp_b,
  input  logic       cmp_lt,
  output logic       busy,
  output logic       done,
  output logic       hit_l,
  output logic       miss_l,
  output logic       hit_r,
  output logic       miss_r,
  output logic       wall_top,
  output logic       wall_bot
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0] state;
  logic [2:0] step;
  logic [7:0] scratch;
  logic [7:0] ball_x_q, ball_y_q, pad_l_q, pad_r_q;
  logic       hit_l_nx, hit_r_nx;

  // Paddle end, saturated so a paddle near the bottom edge still spans to 255.
  function automatic logic [7:0] sat_end(input logic [7:0] y);
    logic [8:0] sum;
    sum = {1'b0, y} + {1'b0, PAD_H};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign busy = (state != IDLE);

  // Snapshot is pure data: no reset needed, only loaded when a pass is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ball_x_q <= ball_x;
      ball_y_q <= ball_y;
      pad_l_q  <= pad_l_y;
      pad_r_q  <= pad_r_y;
    end
  end

  always_comb begin
    cmp_a = 8'd0;
    cmp_b = 8'd0;
    if (state == CMP) begin
      case (step)
        3'd0:    begin cmp_a = ball_x_q; cmp_b = X_LEFT;           end
        3'd1:    begin cmp_a = ball_y_q; cmp_b = pad_l_q;          end
        3'd2:    begin cmp_a = ball_y_q; cmp_b = sat_end(pad_l_q); end
        3'd3:    begin cmp_a = X_RIGHT;  cmp_b = ball_x_q;         end
        3'd4:    begin cmp_a = ball_y_q; cmp_b = pad_r_q;          end
        3'd5:    begin cmp_a = ball_y_q; cmp_b = sat_end(pad_r_q); end
        3'd6:    begin cmp_a = ball_y_q; cmp_b = Y_TOP;            end
        default: begin cmp_a = Y_BOT;    cmp_b = ball_y_q;         end
      endcase
    end
  end

  assign hit_l_nx = scratch[0] & ~scratch[1] & scratch[2];
  assign hit_r_nx = scratch[3] & ~scratch[4] & scratch[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step     <= 3'd0;
      scratch  <= 8'd0;
      done     <= 1'b0;
      hit_l    <= 1'b0;
      miss_l   <= 1'b0;
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
      wall_top <= 1'b0;
      wall_bot <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CMP;
            step  <= 3'd0;
          end
        end
        CMP: begin
          scratch[step] <= cmp_lt;
          if (step == 3'd7) state <= FIN;
          else              step  <= step + 3'd1;
        end
        FIN: begin
          hit_l    <= hit_l_nx;
          miss_l   <= scratch[0] & ~hit_l_nx;
          hit_r    <= hit_r_nx;
          miss_r   <= scratch[3] & ~hit_r_nx;
          wall_top <= scratch[6];
          wall_bot <= scratch[7];
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_seq.sv
// Directed bench for collision_seq with a behavioural model of the shared comparator.
module tb_collision_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ball_x = 8'd0, ball_y = 8'd0, pad_l_y = 8'd0, pad_r_y = 8'd0;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_lt;
  logic       busy, done;
  logic       hit_l, miss_l, hit_r, miss_r, wall_top, wall_bot;
  logic [5:0] flags;

  int vectors = 0;
  int miscompares = 0;

  collision_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt),
    .busy(busy), .done(done),
    .hit_l(hit_l), .miss_l(miss_l), .hit_r(hit_r), .miss_r(miss_r),
    .wall_top(wall_top), .wall_bot(wall_bot)
  );

  assign cmp_lt = (cmp_a < cmp_b);
  // Order: hit_l, miss_l, hit_r, miss_r, wall_top, wall_bot
  assign flags = {hit_l, miss_l, hit_r, miss_r, wall_top, wall_bot};

  always #5 clk = ~clk;

  // Drive start for one cycle; returns #1 after the sampling edge E0.
  task automatic pulse_start(input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] pl, input logic [7:0] pr);
    @(negedge clk);
    ball_x = x; ball_y = y; pad_l_y = pl; pad_r_y = pr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({busy, done, flags, cmp_a, cmp_b} !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h exp 000000", {busy, done, flags, cmp_a, cmp_b});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_left_hit;
    int cyc;
    pulse_start(8'd5, 8'd100, 8'd90, 8'd0);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 2) begin
        vectors++;
        if ({cmp_a, cmp_b} !== {8'd100, 8'd122}) begin
          miscompares++;
          $display("FAIL left_hit_step2 got %0d/%0d exp 100/122", cmp_a, cmp_b);
        end
      end
      if (cyc == 8) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL left_hit_busy_fin got %b exp 1", busy);
        end
      end
      if (done) break;
    end
    vectors++;
    if (cyc !== 9) begin
      miscompares++;
      $display("FAIL left_hit_latency got %0d exp 9", cyc);
    end
    vectors++;
    if ({busy, flags} !== 7'b0_100000) begin
      miscompares++;
      $display("FAIL left_hit_flags got %b exp 0100000", {busy, flags});
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, flags} !== 7'b0_100000) begin
      miscompares++;
      $display("FAIL left_hit_done_fall got %b exp 0100000", {done, flags});
    end
  endtask

  task automatic test_reset_mid_pass;
    int seen;
    pulse_start(8'd5, 8'd100, 8'd90, 8'd50);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if ({busy, cmp_a, cmp_b} !== {1'b1, 8'd100, 8'd50}) begin
      miscompares++;
      $display("FAIL mid_pass_step4 got %b/%0d/%0d exp 1/100/50", busy, cmp_a, cmp_b);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, flags, cmp_a, cmp_b} !== 24'd0) begin
      miscompares++;
      $display("FAIL mid_pass_reset got %h exp 000000", {busy, done, flags, cmp_a, cmp_b});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL mid_pass_no_resume got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic run_pass(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] pl, input logic [7:0] pr,
                          input int chk_step, input logic [7:0] exp_b,
                          input logic [5:0] exp_flags);
    int cyc;
    pulse_start(x, y, pl, pr);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == chk_step) begin
        vectors++;
        if (cmp_b !== exp_b) begin
          miscompares++;
          $display("FAIL %s_cmp_b got %0d exp %0d", name, cmp_b, exp_b);
        end
      end
      if (done) break;
    end
    vectors++;
    if (cyc !== 9) begin
      miscompares++;
      $display("FAIL %s_latency got %0d exp 9", name, cyc);
    end
    vectors++;
    if (flags !== exp_flags) begin
      miscompares++;
      $display("FAIL %s_flags got %b exp %b", name, flags, exp_flags);
    end
  endtask

  task automatic test_boundaries;
    run_pass("left_end_miss", 8'd5, 8'd122, 8'd90, 8'd0, 2, 8'd122, 6'b010000);
    run_pass("left_top_hit", 8'd5, 8'd90, 8'd90, 8'd0, 1, 8'd90, 6'b100000);
    run_pass("right_miss_top", 8'd250, 8'd2, 8'd0, 8'd200, 4, 8'd200, 6'b000110);
    run_pass("saturation", 8'd250, 8'd255, 8'd0, 8'd240, 5, 8'd255, 6'b000101);
  endtask

  task automatic test_snapshot;
    int cyc;
    int seen;
    pulse_start(8'd5, 8'd100, 8'd90, 8'd0);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 3) begin
        start = 1'b1; ball_y = 8'd200; ball_x = 8'd250;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    vectors++;
    if (cyc !== 9) begin
      miscompares++;
      $display("FAIL snapshot_latency got %0d exp 9", cyc);
    end
    vectors++;
    if (flags !== 6'b100000) begin
      miscompares++;
      $display("FAIL snapshot_flags got %b exp 100000", flags);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL snapshot_ignored_start got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    pulse_start(8'd5, 8'd100, 8'd90, 8'd0);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (done) break;
    end
    vectors++;
    if ({cyc, flags} !== {32'd9, 6'b100000}) begin
      miscompares++;
      $display("FAIL b2b_first got cyc %0d flags %b exp cyc 9 flags 100000", cyc, flags);
    end
    ball_x = 8'd250; ball_y = 8'd2; pad_l_y = 8'd0; pad_r_y = 8'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_accept got busy/done %b exp 10", {busy, done});
    end
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (done) break;
    end
    vectors++;
    if (cyc !== 9) begin
      miscompares++;
      $display("FAIL b2b_latency got %0d exp 9", cyc);
    end
    vectors++;
    if (flags !== 6'b000110) begin
      miscompares++;
      $display("FAIL b2b_second_flags got %b exp 000110", flags);
    end
  endtask

  initial begin
    test_reset;
    test_left_hit;
    test_reset_mid_pass;
    test_boundaries;
    test_snapshot;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
